// File: rtl/pc11_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc11_fifo : PC11 paper tape reader/punch with ARM-side reader/punch FIFOs   |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module pc11_fifo #(
  parameter logic [17:0] ADDR     = 18'o777550,
  parameter logic [7:0]  INTVEC   = 8'o070,
  parameter int          FIFOLOG2 = 4,
  parameter logic [15:0] RDRDLY   = 16'd100,
  parameter logic [15:0] PUNDLY   = 16'd100
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  output logic        intreq,
  output logic [7:0]  intvec,
  input  logic [17:0] a_in_h,
  input  logic [1:0]  c_in_h,
  input  logic [15:0] d_in_h,
  input  logic        init_in_h,
  input  logic        msyn_in_h,
  output logic [15:0] d_out_h,
  output logic        ssyn_out_h
);

  localparam int                DEPTH   = 1 << FIFOLOG2;
  localparam int                CW      = FIFOLOG2 + 1;
  localparam logic [CW-1:0]     FULLCNT = CW'(DEPTH);
  localparam logic [CW-1:0]     CONE    = CW'(1);
  localparam logic [FIFOLOG2-1:0] PONE  = FIFOLOG2'(1);
  localparam logic [31:0]       ID      = 32'h50461002;

  typedef enum logic [0:0] {R_IDLE = 1'b0, R_BUSY = 1'b1} rstate_t;
  typedef enum logic [0:0] {P_IDLE = 1'b0, P_WAIT = 1'b1} pstate_t;

  rstate_t rst_q, rst_d;
  pstate_t pst_q, pst_d;

  logic [7:0]          rmem_q [DEPTH];
  logic [7:0]          pmem_q [DEPTH];
  logic [FIFOLOG2-1:0] rwp_q, rwp_d, rrp_q, rrp_d, pwp_q, pwp_d, prp_q, prp_d;
  logic [CW-1:0]       rcnt_q, rcnt_d, pcnt_q, pcnt_d;
  logic                enable_q, enable_d, eof_q, eof_d;
  logic [15:0]         rcsr_q, rcsr_d, pcsr_q, pcsr_d;
  logic [7:0]          rbuf_q, rbuf_d, pbuf_q, pbuf_d;
  logic [15:0]         rdly_q, rdly_d, pdly_q, pdly_d;
  logic [15:0]         dout_q, dout_d;
  logic                ssyn_q, ssyn_d;

  logic        arm1, arm2, arm3;
  logic        bus_go, bus_rd, lo_wr, start, rbuf_rd, pbuf_wr;
  logic [1:0]  sel;
  logic [15:0] bus_rdata;
  logic        r_empty, r_full, p_empty, p_full;
  logic        r_push, r_pop, r_flush, p_push, p_pop, p_flush;
  logic [7:0]  r_head, phead;
  logic        rirq, pirq;
  logic        unused_ok;

  assign unused_ok = ^{armwdata[29:24], armwdata[14:0], d_in_h[15:8]};

  assign arm1 = armwrite && (armwaddr == 2'd1);
  assign arm2 = armwrite && (armwaddr == 2'd2);
  assign arm3 = armwrite && (armwaddr == 2'd3);

  // An ARM write cycle stalls the bus slave for that clock; INIT also blocks it.
  assign bus_go  = enable_q && (a_in_h[17:3] == ADDR[17:3]) && msyn_in_h && !ssyn_q
                   && !armwrite && !init_in_h;
  assign bus_rd  = bus_go && !c_in_h[1];
  assign lo_wr   = bus_go && c_in_h[1] && !(c_in_h[0] && a_in_h[0]);
  assign sel     = a_in_h[2:1];
  assign start   = lo_wr && (sel == 2'd0) && d_in_h[0];
  assign rbuf_rd = bus_rd && (sel == 2'd1);
  assign pbuf_wr = lo_wr && (sel == 2'd3) && pcsr_q[7];

  assign r_empty = (rcnt_q == '0);
  assign r_full  = (rcnt_q == FULLCNT);
  assign p_empty = (pcnt_q == '0);
  assign p_full  = (pcnt_q == FULLCNT);
  assign r_head  = rmem_q[rrp_q];
  assign phead   = p_empty ? 8'h00 : pmem_q[prp_q];

  assign r_flush = arm1 && armwdata[30];
  assign r_push  = arm1 && armwdata[31] && !r_full && !r_flush;
  assign r_pop   = (rst_q == R_BUSY) && (rdly_q == '0) && !r_empty && !start && !init_in_h;
  assign p_flush = arm2 && armwdata[30];
  assign p_pop   = arm2 && armwdata[31] && !p_empty && !p_flush;
  assign p_push  = pbuf_wr && !p_full;

  always_comb begin
    bus_rdata = 16'h0000;
    case (sel)
      2'd0: bus_rdata = rcsr_q & 16'o104300;
      2'd1: bus_rdata = {8'h00, rbuf_q};
      2'd2: bus_rdata = pcsr_q & 16'o100300;
      2'd3: bus_rdata = {8'h00, pbuf_q};
      default: bus_rdata = 16'h0000;
    endcase
  end

  always_comb begin
    armrdata = ID;
    case (armraddr)
      2'd0: armrdata = ID;
      2'd1: armrdata = {8'(rcnt_q), rbuf_q, rcsr_q};
      2'd2: armrdata = {8'(pcnt_q), phead, pcsr_q};
      2'd3: armrdata = {enable_q, eof_q, 4'b0000, INTVEC, ADDR};
      default: armrdata = ID;
    endcase
  end

  assign rirq    = (rcsr_q[15] || rcsr_q[7]) && rcsr_q[6];
  assign pirq    = (pcsr_q[15] || pcsr_q[7]) && pcsr_q[6];
  assign intreq  = rirq || pirq;
  assign intvec  = rirq ? INTVEC : INTVEC + 8'd4;
  assign d_out_h    = dout_q;
  assign ssyn_out_h = ssyn_q;

  always_comb begin
    rwp_d = rwp_q; rrp_d = rrp_q; rcnt_d = rcnt_q;
    pwp_d = pwp_q; prp_d = prp_q; pcnt_d = pcnt_q;
    enable_d = enable_q; eof_d = eof_q;
    if (r_flush) begin
      rwp_d = '0; rrp_d = '0; rcnt_d = '0;
    end else begin
      if (r_push) rwp_d = rwp_q + PONE;
      if (r_pop)  rrp_d = rrp_q + PONE;
      if (r_push && !r_pop)      rcnt_d = rcnt_q + CONE;
      else if (!r_push && r_pop) rcnt_d = rcnt_q - CONE;
    end
    if (p_flush) begin
      pwp_d = '0; prp_d = '0; pcnt_d = '0;
    end else begin
      if (p_push) pwp_d = pwp_q + PONE;
      if (p_pop)  prp_d = prp_q + PONE;
      if (p_push && !p_pop)      pcnt_d = pcnt_q + CONE;
      else if (!p_push && p_pop) pcnt_d = pcnt_q - CONE;
    end
    if (arm3) begin
      enable_d = armwdata[31];
      eof_d    = armwdata[30];
    end
  end

  always_comb begin
    rcsr_d = rcsr_q; rbuf_d = rbuf_q; pcsr_d = pcsr_q; pbuf_d = pbuf_q;
    rdly_d = rdly_q; pdly_d = pdly_q; rst_d = rst_q; pst_d = pst_q;
    dout_d = dout_q; ssyn_d = ssyn_q;

    if (ssyn_q && !msyn_in_h) begin
      ssyn_d = 1'b0;
      dout_d = 16'h0000;
    end else if (bus_go) begin
      ssyn_d = 1'b1;
      dout_d = c_in_h[1] ? 16'h0000 : bus_rdata;
    end
    if (rbuf_rd) rcsr_d[7] = 1'b0;
    if (lo_wr && (sel == 2'd0)) rcsr_d[6] = d_in_h[6];

    // Reader: a start (even while busy) reloads the delay; FSM results override the RBUF-read clear.
    if (start) begin
      rst_d = R_BUSY; rcsr_d[7] = 1'b0; rcsr_d[11] = 1'b1; rbuf_d = 8'h00; rdly_d = RDRDLY;
    end else if (rst_q == R_BUSY) begin
      if (rdly_q != '0) begin
        rdly_d = rdly_q - 16'd1;
      end else if (!r_empty) begin
        rbuf_d = r_head; rcsr_d[11] = 1'b0; rcsr_d[7] = 1'b1; rst_d = R_IDLE;
      end else if (eof_q) begin
        rcsr_d[15] = 1'b1; rcsr_d[11] = 1'b0; rst_d = R_IDLE;
      end
    end

    if (pst_q == P_WAIT) begin
      if (pdly_q != '0) begin
        pdly_d = pdly_q - 16'd1;
      end else if (!p_full) begin
        pcsr_d[7] = 1'b1; pst_d = P_IDLE;
      end
    end
    if (lo_wr && (sel == 2'd2)) pcsr_d[6] = d_in_h[6];
    if (pbuf_wr) begin
      pbuf_d = d_in_h[7:0]; pcsr_d[7] = 1'b0; pst_d = P_WAIT; pdly_d = PUNDLY;
    end

    if (arm1) rcsr_d[15] = armwdata[15];
    if (arm2) pcsr_d[15] = armwdata[15];
  end

  always_ff @(posedge CLOCK) begin
    if (r_push) rmem_q[rwp_q] <= armwdata[23:16];
    if (p_push) pmem_q[pwp_q] <= d_in_h[7:0];
  end

  // FIFO state and enable/eof survive bus INIT; only RESET clears them.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rwp_q <= '0; rrp_q <= '0; rcnt_q <= '0;
      pwp_q <= '0; prp_q <= '0; pcnt_q <= '0;
      enable_q <= 1'b0; eof_q <= 1'b0;
    end else begin
      rwp_q <= rwp_d; rrp_q <= rrp_d; rcnt_q <= rcnt_d;
      pwp_q <= pwp_d; prp_q <= prp_d; pcnt_q <= pcnt_d;
      enable_q <= enable_d; eof_q <= eof_d;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET || init_in_h) begin
      rcsr_q <= 16'o0;   rbuf_q <= 8'h00;
      pcsr_q <= 16'o200; pbuf_q <= 8'h00;
      rdly_q <= '0;      pdly_q <= '0;
      rst_q  <= R_IDLE;  pst_q  <= P_IDLE;
      dout_q <= 16'h0000; ssyn_q <= 1'b0;
    end else begin
      rcsr_q <= rcsr_d;  rbuf_q <= rbuf_d;
      pcsr_q <= pcsr_d;  pbuf_q <= pbuf_d;
      rdly_q <= rdly_d;  pdly_q <= pdly_d;
      rst_q  <= rst_d;   pst_q  <= pst_d;
      dout_q <= dout_d;  ssyn_q <= ssyn_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc11_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pc11_fifo : directed + randomized bench with queue models of both FIFOs  |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_pc11_fifo;

  localparam int          R    = 8;
  localparam int          P    = 4;
  localparam logic [17:0] BASE = 18'o777550;
  localparam logic [7:0]  INTV = 8'o070;
  localparam logic [17:0] RCSR = BASE;
  localparam logic [17:0] RBUF = BASE + 18'd2;
  localparam logic [17:0] PCSR = BASE + 18'd4;
  localparam logic [17:0] PBUF = BASE + 18'd6;

  logic        CLOCK = 1'b0;
  logic        RESET, armwrite, init_in_h, msyn_in_h;
  logic [1:0]  armraddr, armwaddr, c_in_h;
  logic [31:0] armwdata, armrdata;
  logic        intreq, ssyn_out_h;
  logic [7:0]  intvec;
  logic [17:0] a_in_h;
  logic [15:0] d_in_h, d_out_h;

  int checks = 0;
  int errors = 0;
  logic [7:0]  rq[$];
  logic [7:0]  pq[$];
  logic [31:0] v;
  logic [15:0] rd;
  logic [7:0]  b;
  int          n;

  pc11_fifo #(
    .ADDR(BASE), .INTVEC(INTV), .FIFOLOG2(4), .RDRDLY(16'(R)), .PUNDLY(16'(P))
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .armwrite(armwrite), .armraddr(armraddr),
    .armwaddr(armwaddr), .armwdata(armwdata), .armrdata(armrdata),
    .intreq(intreq), .intvec(intvec), .a_in_h(a_in_h), .c_in_h(c_in_h),
    .d_in_h(d_in_h), .init_in_h(init_in_h), .msyn_in_h(msyn_in_h),
    .d_out_h(d_out_h), .ssyn_out_h(ssyn_out_h)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic arm_rd(input logic [1:0] a, output logic [31:0] val);
    armraddr = a;
    #1;
    val = armrdata;
  endtask

  task automatic arm_wr(input logic [1:0] a, input logic [31:0] d);
    armwrite = 1'b1; armwaddr = a; armwdata = d;
    tick();
    armwrite = 1'b0;
  endtask

  task automatic bus_xfer(input logic [17:0] a, input logic wr, input logic bytem,
                          input logic [15:0] d, output logic [15:0] rdata);
    int k;
    a_in_h = a; c_in_h = {wr, bytem}; d_in_h = d; msyn_in_h = 1'b1;
    k = 0;
    while (!ssyn_out_h && k < 10) begin
      tick();
      k++;
    end
    chk("bus_ack", ssyn_out_h, 1);
    rdata = d_out_h;
    msyn_in_h = 1'b0;
    tick();
    chk("bus_release", {15'h0, ssyn_out_h, d_out_h}, 0);
  endtask

  task automatic wait_rready();
    logic [31:0] x;
    int k;
    k = 0;
    arm_rd(1, x);
    while (!x[7] && k < R + 10) begin
      tick();
      arm_rd(1, x);
      k++;
    end
    chk("rdr_ready", x[7], 1);
  endtask

  task automatic wait_pready();
    logic [31:0] x;
    int k;
    k = 0;
    arm_rd(2, x);
    while (!x[7] && k < P + 10) begin
      tick();
      arm_rd(2, x);
      k++;
    end
    chk("pun_ready", x[7], 1);
  endtask

  initial begin
    RESET = 1'b1; armwrite = 1'b0; armraddr = 2'd0; armwaddr = 2'd0; armwdata = '0;
    a_in_h = '0; c_in_h = '0; d_in_h = '0; init_in_h = 1'b0; msyn_in_h = 1'b0;
    repeat (3) tick();
    RESET = 1'b0;
    tick();

    // Reset state
    arm_rd(0, v); chk("id", v, 32'h50461002);
    arm_rd(1, v); chk("reg1_reset", v, 32'h0);
    arm_rd(2, v); chk("reg2_reset", v, 32'o200);
    arm_rd(3, v); chk("reg3_reset", v, {2'b00, 4'b0000, INTV, BASE});
    chk("intreq_reset", intreq, 0);

    // Disabled: no bus response
    a_in_h = RCSR; c_in_h = 2'b00; msyn_in_h = 1'b1;
    repeat (4) tick();
    chk("ssyn_disabled", ssyn_out_h, 0);
    msyn_in_h = 1'b0;
    tick();

    // Basic reader transfer with exact latency
    arm_wr(1, 32'h8041_0000); rq.push_back(8'h41);
    arm_wr(1, 32'h8042_0000); rq.push_back(8'h42);
    arm_rd(1, v); chk("rcount_2", v[31:24], 2);
    arm_wr(3, 32'h8000_0000);
    bus_xfer(RCSR, 1'b1, 1'b0, 16'o101, rd);
    repeat (R - 1) tick();
    arm_rd(1, v); chk("rdy_early", {v[11], v[7]}, 2'b10);
    tick();
    arm_rd(1, v); chk("rdy_on_time", {v[11], v[7]}, 2'b01);
    chk("intreq_rdr", intreq, 1);
    chk("intvec_rdr", intvec, 8'o070);
    bus_xfer(RBUF, 1'b0, 1'b0, 16'h0, rd);
    b = rq.pop_front();
    chk("rbuf_read", rd, {8'h00, b});
    arm_rd(1, v); chk("after_rbuf", {v[31:24], v[7]}, {8'(rq.size()), 1'b0});
    chk("intreq_clear", intreq, 0);

    // Odd-address byte write must not start the reader
    bus_xfer(RCSR + 18'd1, 1'b1, 1'b1, 16'o101, rd);
    repeat (3) tick();
    arm_rd(1, v); chk("odd_byte_no_start", v[11], 0);

    // Empty FIFO: stays busy, then end-of-tape
    arm_wr(1, 32'h4000_0000); rq.delete();
    bus_xfer(RCSR, 1'b1, 1'b0, 16'o101, rd);
    repeat (R + 4) tick();
    arm_rd(1, v); chk("empty_busy", {v[11], v[7]}, 2'b10);
    arm_wr(3, 32'hC000_0000);
    tick();
    arm_rd(1, v); chk("eof_flags", {v[15], v[11]}, 2'b10);
    bus_xfer(RCSR, 1'b0, 1'b0, 16'h0, rd);
    chk("eof_rcsr_read", rd, 16'o100100);
    arm_wr(3, 32'h8000_0000);
    arm_wr(1, 32'h0000_0000);

    // Same-clock ARM push and reader pop at count 3
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      arm_wr(1, {8'h80, b, 16'h0}); rq.push_back(b);
    end
    bus_xfer(RCSR, 1'b1, 1'b0, 16'o101, rd);
    repeat (R - 1) tick();
    b = 8'($urandom);
    arm_wr(1, {8'h80, b, 16'h0}); rq.push_back(b);
    b = rq.pop_front();
    arm_rd(1, v); chk("push_pop_count", v[31:24], 3);
    chk("push_pop_head", {v[23:16], v[7]}, {b, 1'b1});
    bus_xfer(RBUF, 1'b0, 1'b0, 16'h0, rd);
    chk("push_pop_rbuf", rd, {8'h00, b});

    // Flush wins over push
    arm_wr(1, 32'hC0AA_0000); rq.delete();
    arm_rd(1, v); chk("flush_wins", v[31:24], 0);

    // Punch: fill to depth 16
    arm_wr(2, 32'h4000_0000); pq.delete();
    for (int i = 0; i < 16; i++) begin
      wait_pready();
      b = 8'($urandom);
      bus_xfer(PBUF, 1'b1, 1'b0, {8'h00, b}, rd); pq.push_back(b);
    end
    repeat (P + 4) tick();
    arm_rd(2, v); chk("pun_full", {v[31:24], v[23:16], v[7]}, {8'd16, pq[0], 1'b0});
    arm_wr(2, 32'h8000_0000); b = pq.pop_front();
    tick();
    arm_rd(2, v); chk("pun_ready_after_pop", v[7], 1);
    while (pq.size() > 0) begin
      arm_rd(2, v); chk("phead_seq", v[23:16], pq[0]);
      arm_wr(2, 32'h8000_0000); b = pq.pop_front();
    end
    arm_rd(2, v); chk("pun_empty", v[31:16], 16'h0);

    // Punch interrupt vector
    bus_xfer(PCSR, 1'b1, 1'b0, 16'o100, rd);
    chk("pun_int", {intreq, intvec}, {1'b1, 8'o074});
    bus_xfer(PCSR, 1'b1, 1'b0, 16'o000, rd);

    // Randomized mix against the queue models
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          n = $urandom_range(1, 6);
          for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            arm_wr(1, {8'h80, b, 16'h0});
            if (rq.size() < 16) rq.push_back(b);
          end
        end
        1: if (rq.size() > 0) begin
          bus_xfer(RCSR, 1'b1, 1'b0, 16'o101, rd);
          wait_rready();
          bus_xfer(RBUF, 1'b0, 1'b0, 16'h0, rd);
          b = rq.pop_front();
          chk("rnd_rbuf", rd, {8'h00, b});
        end
        2: if (pq.size() < 16) begin
          wait_pready();
          b = 8'($urandom);
          bus_xfer(PBUF, 1'b1, 1'b0, {8'h00, b}, rd); pq.push_back(b);
        end
        default: begin
          arm_rd(2, v);
          chk("rnd_phead", v[23:16], (pq.size() > 0) ? pq[0] : 8'h00);
          arm_wr(2, 32'h8000_0000);
          if (pq.size() > 0) b = pq.pop_front();
        end
      endcase
      arm_rd(1, v); chk("rnd_rcount", v[31:24], rq.size());
      arm_rd(2, v); chk("rnd_pcount", v[31:24], pq.size());
    end

    // INIT during reader busy
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      arm_wr(1, {8'h80, b, 16'h0});
      if (rq.size() < 16) rq.push_back(b);
    end
    bus_xfer(RCSR, 1'b1, 1'b0, 16'o101, rd);
    repeat (2) tick();
    init_in_h = 1'b1;
    tick();
    init_in_h = 1'b0;
    arm_rd(1, v); chk("init_rcsr", {v[31:24], v[15:0]}, {8'(rq.size()), 16'h0});
    arm_rd(2, v); chk("init_pcsr", {v[31:24], v[15:0]}, {8'(pq.size()), 16'o200});
    arm_rd(3, v); chk("init_enable", v[31], 1);
    repeat (R + 4) tick();
    arm_rd(1, v); chk("init_idle", {v[31:24], v[11], v[7]}, {8'(rq.size()), 2'b00});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
